// File: rtl/i_execute.sv
// Execute stage: ID/EX pipeline register, ALU, branch target and redirect.
// Ports: clk/reset, stall, decode bundle in; ALU result, branch, mem ctrl out.
module i_execute #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [WORD-1:0] cur_pc,
  input  logic [WORD-1:0] read_data1,
  input  logic [WORD-1:0] read_data2,
  input  logic [WORD-1:0] sign_extended_output,
  input  logic [10:0]     opcode,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic            branch,
  input  logic            uncondbranch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  output logic            ex_valid,
  output logic [WORD-1:0] alu_result,
  output logic            zero,
  output logic [WORD-1:0] branch_target,
  output logic            pc_src,
  output logic [WORD-1:0] ex_read_data2,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write
);

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  typedef struct packed {
    logic            valid;
    logic [WORD-1:0] pc;
    logic [WORD-1:0] rd1;
    logic [WORD-1:0] rd2;
    logic [WORD-1:0] imm;
    logic [10:0]     opcode;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            uncondbranch;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
  } id_ex_t;

  id_ex_t          id_ex_q;
  id_ex_t          id_ex_d;
  logic            keep;
  logic [WORD-1:0] op_b;
  logic [WORD-1:0] alu_res;

  // A taken redirect overrides stall so the wrong-path
  // instruction is squashed into a bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    keep    = in_valid & ~pc_src;
    if (pc_src || !stall) begin
      id_ex_d.valid        = keep;
      id_ex_d.pc           = cur_pc;
      id_ex_d.rd1          = read_data1;
      id_ex_d.rd2          = read_data2;
      id_ex_d.imm          = sign_extended_output;
      id_ex_d.opcode       = opcode;
      id_ex_d.alu_op       = alu_op;
      id_ex_d.alu_src      = alu_src;
      id_ex_d.branch       = branch;
      id_ex_d.uncondbranch = uncondbranch;
      id_ex_d.mem_read     = mem_read & keep;
      id_ex_d.mem_write    = mem_write & keep;
      id_ex_d.mem_to_reg   = mem_to_reg;
      id_ex_d.reg_write    = reg_write & keep;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  always_comb begin
    op_b    = id_ex_q.alu_src ? id_ex_q.imm : id_ex_q.rd2;
    alu_res = '0;
    unique case (id_ex_q.alu_op)
      2'b00: alu_res = id_ex_q.rd1 + op_b;
      2'b01: alu_res = op_b;
      2'b10: begin
        unique case (1'b1)
          (id_ex_q.opcode == OP_ADD): alu_res = id_ex_q.rd1 + op_b;
          (id_ex_q.opcode == OP_SUB): alu_res = id_ex_q.rd1 - op_b;
          (id_ex_q.opcode == OP_AND): alu_res = id_ex_q.rd1 & op_b;
          (id_ex_q.opcode == OP_ORR): alu_res = id_ex_q.rd1 | op_b;
          default:                    alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_result    = alu_res;
  assign zero          = (alu_res == '0);
  assign branch_target = id_ex_q.pc + (id_ex_q.imm << 2);
  assign ex_valid      = id_ex_q.valid;
  assign pc_src        = id_ex_q.valid &
                         (id_ex_q.uncondbranch |
                          (id_ex_q.branch & zero));
  assign ex_read_data2 = id_ex_q.rd2;
  assign ex_mem_read   = id_ex_q.mem_read & id_ex_q.valid;
  assign ex_mem_write  = id_ex_q.mem_write & id_ex_q.valid;
  assign ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign ex_reg_write  = id_ex_q.reg_write & id_ex_q.valid;

endmodule

// File: tb/tb_i_execute.sv
// Self-checking bench for i_execute: directed cases plus random
// stimulus compared with a behavioural execute-stage model.
module tb_i_execute;

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND_ = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        in_valid;
  logic [63:0] cur_pc;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] sign_extended_output;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        branch;
  logic        uncondbranch;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        ex_valid;
  logic [63:0] alu_result;
  logic        zero;
  logic [63:0] branch_target;
  logic        pc_src;
  logic [63:0] ex_read_data2;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;

  int errors = 0;
  int checks = 0;

  // model of the instruction currently in execute
  logic        m_valid;
  logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [10:0] m_opc;
  logic [1:0]  m_aop;
  logic        m_asrc, m_br, m_ub, m_mr, m_mw, m_mtr, m_rw;

  i_execute #(.WORD(64)) dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
    .cur_pc(cur_pc), .read_data1(read_data1),
    .read_data2(read_data2),
    .sign_extended_output(sign_extended_output),
    .opcode(opcode), .alu_op(alu_op), .alu_src(alu_src),
    .branch(branch), .uncondbranch(uncondbranch),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .ex_valid(ex_valid), .alu_result(alu_result), .zero(zero),
    .branch_target(branch_target), .pc_src(pc_src),
    .ex_read_data2(ex_read_data2), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_alu();
    logic [63:0] b;
    b = m_asrc ? m_imm : m_rd2;
    case (m_aop)
      2'd0: return m_rd1 + b;
      2'd1: return b;
      2'd2: begin
        if (m_opc == ADD) return m_rd1 + b;
        if (m_opc == SUB) return m_rd1 - b;
        if (m_opc == AND_) return m_rd1 & b;
        if (m_opc == ORR) return m_rd1 | b;
        return 64'd0;
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic m_pcsrc();
    return m_valid && (m_ub || (m_br && m_alu() == 64'd0));
  endfunction

  task automatic m_reset();
    m_valid = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    m_opc = 0; m_aop = 0; m_asrc = 0; m_br = 0; m_ub = 0;
    m_mr = 0; m_mw = 0; m_mtr = 0; m_rw = 0;
  endtask

  task automatic cmp_all(input string t);
    chk({t, ".valid"}, 64'(ex_valid), 64'(m_valid));
    chk({t, ".pc_src"}, 64'(pc_src), 64'(m_pcsrc()));
    chk({t, ".mr"}, 64'(ex_mem_read), 64'(m_valid & m_mr));
    chk({t, ".mw"}, 64'(ex_mem_write), 64'(m_valid & m_mw));
    chk({t, ".rw"}, 64'(ex_reg_write), 64'(m_valid & m_rw));
    if (m_valid) begin
      chk({t, ".alu"}, alu_result, m_alu());
      chk({t, ".zero"}, 64'(zero), 64'(m_alu() == 64'd0));
      chk({t, ".tgt"}, branch_target, m_pc + (m_imm * 4));
      chk({t, ".rd2"}, ex_read_data2, m_rd2);
      chk({t, ".mtr"}, 64'(ex_mem_to_reg), 64'(m_mtr));
    end
  endtask

  task automatic step(input string t);
    logic squash;
    @(posedge clk);
    squash = m_pcsrc();
    if (squash || !stall) begin
      m_valid = in_valid && !squash;
      m_pc = cur_pc; m_rd1 = read_data1; m_rd2 = read_data2;
      m_imm = sign_extended_output; m_opc = opcode;
      m_aop = alu_op; m_asrc = alu_src; m_br = branch;
      m_ub = uncondbranch; m_mr = mem_read; m_mw = mem_write;
      m_mtr = mem_to_reg; m_rw = reg_write;
    end
    #1;
    cmp_all(t);
  endtask

  task automatic clr_in();
    stall = 0; in_valid = 0; cur_pc = 0; read_data1 = 0;
    read_data2 = 0; sign_extended_output = 0; opcode = 0;
    alu_op = 0; alu_src = 0; branch = 0; uncondbranch = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
  endtask

  task automatic rand_in();
    logic [10:0] ops [5];
    ops[0] = ADD; ops[1] = SUB; ops[2] = AND_; ops[3] = ORR;
    ops[4] = 11'($urandom);
    stall = ($urandom_range(0, 3) == 0);
    in_valid = ($urandom_range(0, 4) != 0);
    cur_pc = {$urandom, $urandom};
    read_data1 = {$urandom, $urandom};
    read_data2 = ($urandom_range(0, 3) == 0) ? 64'd0 :
                 {$urandom, $urandom};
    sign_extended_output = {$urandom, $urandom};
    opcode = ops[$urandom_range(0, 4)];
    alu_op = 2'($urandom);
    alu_src = 1'($urandom);
    branch = ($urandom_range(0, 2) == 0);
    uncondbranch = ($urandom_range(0, 5) == 0);
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
  endtask

  task automatic async_reset(input string t);
    #2 reset = 1;
    m_reset();
    #1;
    chk({t, ".rst_valid"}, 64'(ex_valid), 64'd0);
    chk({t, ".rst_pcsrc"}, 64'(pc_src), 64'd0);
    chk({t, ".rst_alu"}, alu_result, 64'd0);
    chk({t, ".rst_zero"}, 64'(zero), 64'd1);
    chk({t, ".rst_tgt"}, branch_target, 64'd0);
    #1 reset = 0;
  endtask

  initial begin
    clr_in();
    m_reset();
    reset = 1;
    #3;
    chk("reset.valid", 64'(ex_valid), 64'd0);
    chk("reset.zero", 64'(zero), 64'd1);
    chk("reset.alu", alu_result, 64'd0);
    chk("reset.tgt", branch_target, 64'd0);
    chk("reset.ctl", 64'({ex_mem_read, ex_mem_write,
                          ex_reg_write, ex_mem_to_reg, pc_src}), 64'd0);
    #9 reset = 0;

    clr_in(); in_valid = 1; read_data1 = 16;
    sign_extended_output = 64'h40; alu_src = 1;
    mem_read = 1; mem_to_reg = 1; reg_write = 1;
    step("ldur");
    chk("ldur.alu", alu_result, 64'h50);
    chk("ldur.zero", 64'(zero), 64'd0);
    chk("ldur.mr", 64'(ex_mem_read), 64'd1);
    chk("ldur.rw", 64'(ex_reg_write), 64'd1);
    chk("ldur.pcsrc", 64'(pc_src), 64'd0);

    clr_in(); in_valid = 1; read_data1 = 20; read_data2 = 20;
    alu_op = 2'b10; opcode = SUB; reg_write = 1;
    step("sub");
    chk("sub.alu", alu_result, 64'd0);
    chk("sub.zero", 64'(zero), 64'd1);

    read_data1 = 64'hF0; read_data2 = 64'h0F; opcode = ORR;
    step("orr");
    chk("orr.alu", alu_result, 64'hFF);

    opcode = 11'h000;
    step("nop_op");
    chk("badop.alu", alu_result, 64'd0);

    clr_in(); in_valid = 1; cur_pc = 16; read_data2 = 0;
    sign_extended_output = -64'sd5; branch = 1; alu_op = 2'b01;
    step("cbz");
    chk("cbz.pcsrc", 64'(pc_src), 64'd1);
    chk("cbz.tgt", branch_target, 64'hFFFF_FFFF_FFFF_FFFC);
    clr_in(); in_valid = 1; reg_write = 1; mem_write = 1;
    step("cbz_sq");
    chk("cbz.squash", 64'(ex_valid), 64'd0);
    chk("cbz.squash_mw", 64'(ex_mem_write), 64'd0);

    clr_in(); in_valid = 1; cur_pc = 24;
    sign_extended_output = 64; uncondbranch = 1;
    step("b");
    chk("b.tgt", branch_target, 64'd280);
    chk("b.pcsrc", 64'(pc_src), 64'd1);
    clr_in(); stall = 1; in_valid = 1; reg_write = 1;
    step("b_sq");
    chk("b.stall_squash", 64'(ex_valid), 64'd0);

    clr_in(); in_valid = 1; read_data1 = 100; read_data2 = 7;
    alu_op = 2'b10; opcode = ADD; reg_write = 1;
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      rand_in(); stall = 1; uncondbranch = 0;
      step("stall");
      chk("stall.alu", alu_result, 64'd107);
      chk("stall.valid", 64'(ex_valid), 64'd1);
    end
    clr_in(); in_valid = 1; read_data1 = 9; read_data2 = 4;
    alu_op = 2'b10; opcode = SUB;
    step("release");
    chk("release.alu", alu_result, 64'd5);

    clr_in(); in_valid = 1; cur_pc = 8;
    sign_extended_output = 3; uncondbranch = 1;
    step("b_rst");
    chk("b_rst.pcsrc", 64'(pc_src), 64'd1);
    async_reset("midrst");

    for (int i = 0; i < 400; i++) begin
      rand_in();
      step("rand");
      if ($urandom_range(0, 40) == 0) async_reset("randrst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i_execute.md
I_EXECUTE -- requirements
Module: i_execute

Interface
REQ-001 SHALL provide parameter WORD, default 64, datapath width.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide stall  input  1  hold the pipeline register when 1.
REQ-005 SHALL provide in_valid  input  1  decode-stage instruction present.
REQ-006 SHALL provide cur_pc  input  WORD  PC of the decode-stage instruction.
REQ-007 SHALL provide read_data1, read_data2  input  WORD each  register operands.
REQ-008 SHALL provide sign_extended_output  input  WORD  immediate from decode.
REQ-009 SHALL provide opcode  input  11  instruction[31:21].
REQ-010 SHALL provide alu_op  input  2  and alu_src, branch, uncondbranch, mem_read, mem_write, mem_to_reg, reg_write  input  1 each  decode control.
REQ-011 SHALL provide ex_valid  output  1  execute-stage instruction valid.
REQ-012 SHALL provide alu_result  output  WORD  ALU output.
REQ-013 SHALL provide zero  output  1  alu_result == 0.
REQ-014 SHALL provide branch_target  output  WORD  computed target to fetch.
REQ-015 SHALL provide pc_src  output  1  redirect fetch to branch_target.
REQ-016 SHALL provide ex_read_data2  output  WORD, plus ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  output  1 each, all registered copies forwarded to memory stage.

Function
REQ-017 SHALL capture all decode inputs into an ID/EX pipeline register on posedge clk when stall=0; ex_valid takes in_valid.
REQ-018 SHALL hold every pipeline-register field unchanged when stall=1 and pc_src=0.
REQ-019 SHALL compute alu_result, zero, branch_target, pc_src combinationally from the pipeline register only (latency: one clock from decode inputs to outputs).
REQ-020 SHALL select ALU operand B = registered immediate when alu_src=1, else registered read_data2.
REQ-021 SHALL decode ALU operation: alu_op 00 -> A+B; 01 -> pass B; 10 -> by opcode: 10001011000 ADD, 11001011000 SUB (A-B), 10001010000 AND, 10101010000 ORR; alu_op 11 or any other opcode -> result 0.
REQ-022 SHALL perform all arithmetic modulo 2^WORD, no overflow flag, no saturation.
REQ-023 SHALL compute branch_target = registered cur_pc + (registered immediate << 2), two's complement, wrap-around modulo 2^WORD.
REQ-024 SHALL drive pc_src = ex_valid & (uncondbranch | (branch & zero)).
REQ-025 SHALL, on a posedge with pc_src=1, load a bubble (ex_valid=0, ex_mem_write=0, ex_reg_write=0, ex_mem_read=0) regardless of stall, squashing the wrong-path decode instruction.
REQ-026 SHALL force ex_mem_write, ex_reg_write, ex_mem_read, pc_src to 0 whenever ex_valid=0, regardless of other register contents.
REQ-027 SHALL treat in_valid=0 capture as a bubble identical to REQ-025.

Reset
REQ-028 SHALL on reset=1 immediately (without clock) clear all pipeline-register fields to 0: ex_valid=0, pc_src=0, alu_result=0, zero=1, branch_target=0, all ex_* controls 0.
REQ-029 SHALL, when reset asserts mid-operation including during stall or a taken branch, discard the in-flight instruction; first capture occurs at first posedge after reset deasserts.

Verification
REQ-030 SHALL cover LDUR: read_data1=16, imm=0x40, alu_op=00, alu_src=1, in_valid=1 -> next cycle alu_result=0x50, zero=0, ex_mem_read=1, ex_reg_write=1, pc_src=0.
REQ-031 SHALL cover R-type: rd1=20, rd2=20, alu_op=10, opcode SUB -> alu_result=0, zero=1; opcode ORR with rd1=0xF0, rd2=0x0F -> 0xFF; opcode 0x000 -> 0.
REQ-032 SHALL cover CBZ taken: cur_pc=16, rd2=0, imm=-5, branch=1, alu_op=01 -> pc_src=1, branch_target=0xFFFFFFFFFFFFFFFC; next posedge ex_valid=0 even with in_valid=1.
REQ-033 SHALL cover B: cur_pc=24, imm=64, uncondbranch=1 -> branch_target=280, pc_src=1; with stall=1 same edge -> bubble still loaded.
REQ-034 SHALL cover stall: stall=1 for 3 cycles with changing inputs -> all outputs constant; release -> captures current inputs next edge.
REQ-035 SHALL cover asynchronous reset asserted between edges while pc_src=1 -> pc_src and ex_valid drop to 0 before next posedge.
